// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control sequencer: opcodes, T-state
// encodings and the packed control word.
package sap_pkg;

    localparam logic [3:0] OPC_LDA = 4'h0;
    localparam logic [3:0] OPC_ADD = 4'h1;
    localparam logic [3:0] OPC_SUB = 4'h2;
    localparam logic [3:0] OPC_OUT = 4'hE;
    localparam logic [3:0] OPC_HLT = 4'hF;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    typedef struct packed {
        logic pcInc;
        logic pcOut;
        logic marLoad;
        logic ramOut;
        logic irLoad;
        logic irOut;
        logic aLoad;
        logic aSend;
        logic bLoad;
        logic aluSub;
        logic aluSend;
        logic outLoad;
    } ctrl_t;

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot T-state ring with early return to T1 and a hold input used by halt.
//
// state | meaning
// T1    | fetch: PC -> MAR
// T2    | fetch: increment PC
// T3    | fetch: RAM -> IR
// T4    | execute step 1
// T5    | execute step 2
// T6    | execute step 3, then back to T1
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       earlyEnd,
    input  logic       hold,
    output logic [5:0] tState
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tState <= T1;
        end else if (!hold) begin
            if (earlyEnd) begin
                tState <= T1;
            end else begin
                // Any non-one-hot value recovers to T1 rather than locking up.
                case (tState)
                    T1:      tState <= T2;
                    T2:      tState <= T3;
                    T3:      tState <= T4;
                    T4:      tState <= T5;
                    T5:      tState <= T6;
                    default: tState <= T1;
                endcase
            end
        end
    end

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP control sequencer: opcode decode into the control word, halt flag,
// and the T-state ring counter.
module sap_controller_sequencer
    import sap_pkg::*;
#(
    parameter int                    OPCODE_W  = 4,
    parameter logic                  EARLY_END = 1'b0,
    parameter logic [OPCODE_W-1:0]   OP_LDA    = OPCODE_W'(OPC_LDA),
    parameter logic [OPCODE_W-1:0]   OP_ADD    = OPCODE_W'(OPC_ADD),
    parameter logic [OPCODE_W-1:0]   OP_SUB    = OPCODE_W'(OPC_SUB),
    parameter logic [OPCODE_W-1:0]   OP_OUT    = OPCODE_W'(OPC_OUT),
    parameter logic [OPCODE_W-1:0]   OP_HLT    = OPCODE_W'(OPC_HLT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_inc,
    output logic                pc_out,
    output logic                mar_load,
    output logic                ram_out,
    output logic                ir_load,
    output logic                ir_out,
    output logic                a_load,
    output logic                a_send,
    output logic                b_load,
    output logic                alu_sub,
    output logic                alu_send,
    output logic                out_load,
    output logic                halted,
    output logic [5:0]          t_state
);

    logic [5:0] tState;
    logic       isLda, isAdd, isSub, isOut, isHlt;
    logic       haltNow, earlyEnd, hold;
    ctrl_t      ctrl, ctrlOut;

    assign isLda = (opcode == OP_LDA);
    assign isAdd = (opcode == OP_ADD);
    assign isSub = (opcode == OP_SUB);
    assign isOut = (opcode == OP_OUT);
    assign isHlt = (opcode == OP_HLT);

    always_comb begin
        ctrl = '0;
        case (tState)
            T1: begin
                ctrl.pcOut   = 1'b1;
                ctrl.marLoad = 1'b1;
            end
            T2: ctrl.pcInc = 1'b1;
            T3: begin
                ctrl.ramOut = 1'b1;
                ctrl.irLoad = 1'b1;
            end
            T4: begin
                if (isLda || isAdd || isSub) begin
                    ctrl.irOut   = 1'b1;
                    ctrl.marLoad = 1'b1;
                end else if (isOut) begin
                    ctrl.aSend   = 1'b1;
                    ctrl.outLoad = 1'b1;
                end
            end
            T5: begin
                if (isLda) begin
                    ctrl.ramOut = 1'b1;
                    ctrl.aLoad  = 1'b1;
                end else if (isAdd || isSub) begin
                    ctrl.ramOut = 1'b1;
                    ctrl.bLoad  = 1'b1;
                end
            end
            T6: begin
                if (isAdd || isSub) begin
                    ctrl.aluSend = 1'b1;
                    ctrl.aLoad   = 1'b1;
                    ctrl.aluSub  = isSub;
                end
            end
            default: ctrl = '0;
        endcase
    end

    // Halting freezes the ring on T4 in the same edge that sets the flag.
    assign haltNow  = (tState == T4) && isHlt && !halted;
    assign hold     = halted || haltNow;
    assign earlyEnd = EARLY_END &&
                      (((tState == T5) && isLda) ||
                       ((tState == T4) && !(isLda || isAdd || isSub || isHlt)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted <= 1'b0;
        end else if (haltNow) begin
            halted <= 1'b1;
        end
    end

    sap_ring_counter uRing (
        .clk      (clk),
        .reset    (reset),
        .earlyEnd (earlyEnd),
        .hold     (hold),
        .tState   (tState)
    );

    // Reset gates the strobes directly so they drop without waiting for an edge.
    assign ctrlOut = (reset || halted) ? '0 : ctrl;

    assign pc_inc   = ctrlOut.pcInc;
    assign pc_out   = ctrlOut.pcOut;
    assign mar_load = ctrlOut.marLoad;
    assign ram_out  = ctrlOut.ramOut;
    assign ir_load  = ctrlOut.irLoad;
    assign ir_out   = ctrlOut.irOut;
    assign a_load   = ctrlOut.aLoad;
    assign a_send   = ctrlOut.aSend;
    assign b_load   = ctrlOut.bLoad;
    assign alu_sub  = ctrlOut.aluSub;
    assign alu_send = ctrlOut.aluSend;
    assign out_load = ctrlOut.outLoad;
    assign t_state  = tState;

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Self-checking bench: a fixed-length instance and an early-end instance,
// table-driven instruction walks plus halt and async-reset sequences.
module tb_sap_controller_sequencer;

    localparam logic [11:0] PCI  = 12'h800;
    localparam logic [11:0] PCO  = 12'h400;
    localparam logic [11:0] MARL = 12'h200;
    localparam logic [11:0] RAMO = 12'h100;
    localparam logic [11:0] IRL  = 12'h080;
    localparam logic [11:0] IRO  = 12'h040;
    localparam logic [11:0] AL   = 12'h020;
    localparam logic [11:0] AS   = 12'h010;
    localparam logic [11:0] BL   = 12'h008;
    localparam logic [11:0] SUBC = 12'h004;
    localparam logic [11:0] ALUS = 12'h002;
    localparam logic [11:0] OUTL = 12'h001;
    localparam logic [11:0] NONE = 12'h000;
    localparam logic [11:0] DRIVERS = PCO | RAMO | IRO | AS | ALUS;

    logic       clk = 1'b0;
    logic       r0 = 1'b1, r1 = 1'b1;
    logic [3:0] op0 = 4'h0, op1 = 4'h0;
    logic       pi0, po0, ml0, ro0, il0, io0, al0, as0, bl0, su0, an0, ol0, h0;
    logic       pi1, po1, ml1, ro1, il1, io1, al1, as1, bl1, su1, an1, ol1, h1;
    logic [5:0] t0, t1;
    logic [11:0] c0, c1;

    int passCnt = 0;
    int totalCnt = 0;

    typedef struct {
        int          dut;
        logic [3:0]  op;
        logic [5:0]  t;
        logic [11:0] c;
    } vec_t;

    typedef struct {
        int          dut;
        string       nm;
        logic [5:0]  t;
        logic [11:0] c;
        logic        h;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sap_controller_sequencer #(.EARLY_END(1'b0)) dut0 (
        .clk(clk), .reset(r0), .opcode(op0),
        .pc_inc(pi0), .pc_out(po0), .mar_load(ml0), .ram_out(ro0), .ir_load(il0),
        .ir_out(io0), .a_load(al0), .a_send(as0), .b_load(bl0), .alu_sub(su0),
        .alu_send(an0), .out_load(ol0), .halted(h0), .t_state(t0)
    );

    sap_controller_sequencer #(.EARLY_END(1'b1)) dut1 (
        .clk(clk), .reset(r1), .opcode(op1),
        .pc_inc(pi1), .pc_out(po1), .mar_load(ml1), .ram_out(ro1), .ir_load(il1),
        .ir_out(io1), .a_load(al1), .a_send(as1), .b_load(bl1), .alu_sub(su1),
        .alu_send(an1), .out_load(ol1), .halted(h1), .t_state(t1)
    );

    assign c0 = {pi0, po0, ml0, ro0, il0, io0, al0, as0, bl0, su0, an0, ol0};
    assign c1 = {pi1, po1, ml1, ro1, il1, io1, al1, as1, bl1, su1, an1, ol1};

    // Push the expectation, let outputs settle, then pop and compare.
    task automatic chk(input int d, input string nm, input logic [5:0] t,
                       input logic [11:0] c, input logic h);
        exp_t e;
        logic [5:0]  at;
        logic [11:0] ac;
        logic        ah;
        e.dut = d; e.nm = nm; e.t = t; e.c = c; e.h = h;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        at = (e.dut == 0) ? t0 : t1;
        ac = (e.dut == 0) ? c0 : c1;
        ah = (e.dut == 0) ? h0 : h1;
        totalCnt++;
        if (at === e.t && ac === e.c && ah === e.h) passCnt++;
        else $display("FAIL %s dut%0d: got t=%h ctrl=%h halted=%b, want t=%h ctrl=%h halted=%b",
                      e.nm, e.dut, at, ac, ah, e.t, e.c, e.h);
        totalCnt++;
        if ($countones(ac & DRIVERS) <= 1) passCnt++;
        else $display("FAIL %s_bus dut%0d: got drivers=%h, want at most one", e.nm, e.dut, ac & DRIVERS);
    endtask

    vec_t vecs[$];

    task automatic addv(input int d, input logic [3:0] op, input logic [5:0] t, input logic [11:0] c);
        vec_t v;
        v.dut = d; v.op = op; v.t = t; v.c = c;
        vecs.push_back(v);
    endtask

    initial begin
        // dut0 fixed length: LDA, SUB, undefined 4'h7, then next fetch.
        addv(0, 4'h0, 6'h01, PCO | MARL);
        addv(0, 4'h0, 6'h02, PCI);
        addv(0, 4'hF, 6'h04, RAMO | IRL);
        addv(0, 4'h0, 6'h08, IRO | MARL);
        addv(0, 4'h0, 6'h10, RAMO | AL);
        addv(0, 4'h0, 6'h20, NONE);
        addv(0, 4'hE, 6'h01, PCO | MARL);
        addv(0, 4'hF, 6'h02, PCI);
        addv(0, 4'h2, 6'h04, RAMO | IRL);
        addv(0, 4'h2, 6'h08, IRO | MARL);
        addv(0, 4'h2, 6'h10, RAMO | BL);
        addv(0, 4'h2, 6'h20, ALUS | SUBC | AL);
        addv(0, 4'h7, 6'h01, PCO | MARL);
        addv(0, 4'h7, 6'h02, PCI);
        addv(0, 4'h7, 6'h04, RAMO | IRL);
        addv(0, 4'h7, 6'h08, NONE);
        addv(0, 4'h7, 6'h10, NONE);
        addv(0, 4'h7, 6'h20, NONE);
        addv(0, 4'h7, 6'h01, PCO | MARL);
        // dut1 early end: OUT (4 clocks), LDA (5 clocks), ADD (6 clocks).
        addv(1, 4'hE, 6'h01, PCO | MARL);
        addv(1, 4'hE, 6'h02, PCI);
        addv(1, 4'hE, 6'h04, RAMO | IRL);
        addv(1, 4'hE, 6'h08, AS | OUTL);
        addv(1, 4'h0, 6'h01, PCO | MARL);
        addv(1, 4'h0, 6'h02, PCI);
        addv(1, 4'h0, 6'h04, RAMO | IRL);
        addv(1, 4'h0, 6'h08, IRO | MARL);
        addv(1, 4'h0, 6'h10, RAMO | AL);
        addv(1, 4'h1, 6'h01, PCO | MARL);
        addv(1, 4'h1, 6'h02, PCI);
        addv(1, 4'h1, 6'h04, RAMO | IRL);
        addv(1, 4'h1, 6'h08, IRO | MARL);
        addv(1, 4'h1, 6'h10, RAMO | BL);
        addv(1, 4'h1, 6'h20, ALUS | AL);
        addv(1, 4'h1, 6'h01, PCO | MARL);

        // Reset state while reset held, opcode set to halt to show it is ignored.
        op0 = 4'hF; op1 = 4'hF;
        @(negedge clk);
        chk(0, "reset_state", 6'h01, NONE, 1'b0);
        #1 chk(1, "reset_state", 6'h01, NONE, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].dut != vecs[i-1].dut) begin
                @(negedge clk);
                r0 = 1'b1; r1 = 1'b1;
                @(negedge clk);
                if (vecs[i].dut == 0) r0 = 1'b0; else r1 = 1'b0;
            end else begin
                @(negedge clk);
            end
            if (vecs[i].dut == 0) op0 = vecs[i].op; else op1 = vecs[i].op;
            chk(vecs[i].dut, $sformatf("vec%0d", i), vecs[i].t, vecs[i].c, 1'b0);
        end

        // Halt: freezes on T4 with controls off until reset.
        @(negedge clk);
        r0 = 1'b1; r1 = 1'b1; op0 = 4'hF;
        @(negedge clk);
        r0 = 1'b0;
        chk(0, "hlt_t1", 6'h01, PCO | MARL, 1'b0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk(0, "hlt_t4", 6'h08, NONE, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 10) op0 = 4'h1;
            chk(0, $sformatf("hlt_hold%0d", k), 6'h08, NONE, 1'b1);
        end
        @(negedge clk);
        r0 = 1'b1;
        chk(0, "hlt_reset", 6'h01, NONE, 1'b0);

        // Async reset mid-T5 of ADD, then a full ADD after release.
        @(negedge clk);
        r0 = 1'b0; op0 = 4'h1;
        repeat (4) @(negedge clk);
        chk(0, "add_t5", 6'h10, RAMO | BL, 1'b0);
        #1 r0 = 1'b1;
        chk(0, "async_reset", 6'h01, NONE, 1'b0);
        @(negedge clk);
        r0 = 1'b0;
        chk(0, "add2_t1", 6'h01, PCO | MARL, 1'b0);
        @(negedge clk); chk(0, "add2_t2", 6'h02, PCI, 1'b0);
        @(negedge clk); chk(0, "add2_t3", 6'h04, RAMO | IRL, 1'b0);
        @(negedge clk); chk(0, "add2_t4", 6'h08, IRO | MARL, 1'b0);
        @(negedge clk); chk(0, "add2_t5", 6'h10, RAMO | BL, 1'b0);
        @(negedge clk); chk(0, "add2_t6", 6'h20, ALUS | AL, 1'b0);
        @(negedge clk); chk(0, "add2_wrap", 6'h01, PCO | MARL, 1'b0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/sap_controller_sequencer.md
Name: sap_controller_sequencer

Overview:
- Control sequencer for the 8-bit SAP-style datapath.
- Steps a one-hot ring counter through fetch (T1-T3) and execute (T4-T6) T-states, and decodes the IR opcode into the control word.
- The control word drives the load/send strobes of the PC, MAR, RAM, IR, accumulator, B register, ALU and output register.
- Sits directly upstream of the accumulator: it generates that register's load and send strobes and the ALU subtract/send controls.

Parameters:
OPCODE_W, 4, width of the opcode field from the IR
EARLY_END, 0, 1 = instructions with trailing no-op T-states return to T1 early (variable-length cycle); 0 = fixed 6 T-states per instruction
OP_LDA, 4'h0, opcode for load-accumulator
OP_ADD, 4'h1, opcode for add
OP_SUB, 4'h2, opcode for subtract
OP_OUT, 4'hE, opcode for output
OP_HLT, 4'hF, opcode for halt

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; returns the sequencer to T1, not halted
opcode  input  OPCODE_W  IR upper nibble; stable from the end of T3
pc_inc  output  1  increment program counter
pc_out  output  1  PC drives bus
mar_load  output  1  MAR loads from bus
ram_out  output  1  RAM drives bus
ir_load  output  1  IR loads from bus
ir_out  output  1  IR operand nibble drives bus
a_load  output  1  accumulator loads from bus
a_send  output  1  accumulator drives bus
b_load  output  1  B register loads from bus
alu_sub  output  1  ALU subtracts (A-B) instead of adding
alu_send  output  1  ALU result drives bus
out_load  output  1  output register loads from bus
halted  output  1  sequencer stopped by HLT
t_state  output  6  one-hot current T-state; bit0 = T1

Behaviour:
- The state register is a one-hot ring T1..T6 plus a HALT flag. Both update on the rising edge of clk and reset asynchronously.
- While reset is high:
  - t_state = 6'b000001 and halted = 0.
  - All control outputs are forced to 0, regardless of decode.
- Control outputs are combinational from the current T-state and opcode (Moore per T-state). At most one bus driver is asserted in any T-state.
- Fetch sequence, identical for all opcodes:
  - T1: pc_out, mar_load.
  - T2: pc_inc.
  - T3: ram_out, ir_load.
- Execute sequence by opcode:
  - LDA: T4 ir_out, mar_load; T5 ram_out, a_load; T6 none.
  - ADD: T4 ir_out, mar_load; T5 ram_out, b_load; T6 alu_send, a_load.
  - SUB: same as ADD, with alu_sub also asserted in T6.
  - OUT: T4 a_send, out_load; T5 and T6 none.
  - HLT: T4 asserts no controls; the edge ending T4 sets halted = 1.
  - Undefined opcodes: T4-T6 assert no controls (NOP).
- Transitions:
  - Each edge advances Tn to Tn+1; T6 goes to T1.
  - With EARLY_END = 1: LDA goes T5→T1; OUT and undefined opcodes go T4→T1; ADD/SUB always use T6.
- Halt:
  - Once halted = 1, t_state holds its value and all controls are 0 on every edge until reset.
  - Only reset clears halted.
- Reset mid-instruction: immediate return to T1. No partial strobe completes, i.e. outputs drop to 0 asynchronously.
- Reset release: T1 outputs appear immediately. The first rising edge after release moves to T2.
- The opcode is sampled only in T4-T6. Changes in T1-T3 have no effect.

Decomposition:
- Shared package sap_pkg holds:
  - opcode localparams (LDA/ADD/SUB/OUT/HLT);
  - the T-state one-hot encodings;
  - a packed control-word struct ordered {pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out, a_load, a_send, b_load, alu_sub, alu_send, out_load}.
- Sub-module sap_ring_counter: one-hot 6-state ring with async reset, an early-return input and a hold input (halt).
- The top level holds the opcode decoder and the halt flag.

Test Plan:
- Reset, then 6 clocks with opcode=4'h0 (LDA), EARLY_END=0:
  - t_state walks 01,02,04,08,10,20 then back to 01.
  - Asserted controls per state are {pc_out,mar_load}, {pc_inc}, {ram_out,ir_load}, {ir_out,mar_load}, {ram_out,a_load}, none.
- opcode=4'h2 (SUB): in T6, alu_send=1, alu_sub=1 and a_load=1, with all other controls 0. In T5, b_load=1 and alu_sub=0.
- opcode=4'hE (OUT) with EARLY_END=1:
  - T4 shows a_send=1 and out_load=1.
  - The next edge gives t_state=6'b000001; the instruction is 4 clocks total.
- opcode=4'hF (HLT):
  - After the T4 edge, halted=1 and t_state=6'b001000 held for 20 clocks with all controls 0.
  - Asserting reset gives halted=0 and t_state=01.
- Assert reset asynchronously mid-T5 of ADD (between edges):
  - Controls go to 0 and t_state=01 without waiting for a clock.
  - After release, a full 6-state ADD executes.
- Undefined opcode 4'h7: T4-T6 show all controls 0, no bus driver is asserted, and the sequence returns to T1.
